i2c_target: RTL
===============

# i2c_target

I2C target (slave) controller: the responder end of the bus driven by the team's I2C master core. Oversamples `scl`/`sda` on `clk_in`, detects START/repeated START/STOP, matches a fixed 7-bit address, ACKs it, then shifts write bytes out to the user and read bytes in from the user over single-cycle handshakes. SDA is open-drain only. SCL is driven only when clock stretching is compiled in.

## Interface
- `ADDRESS`, default 7'h50: 7-bit target address.
- `FILTER_DEPTH`, default 3: number of consecutive equal samples required before a filtered `scl`/`sda` level changes (glitch filter), range 1–7.
- `clk_in` in 1: system clock. Frequency must be at least 16× the bus SCL rate.
- `reset` in 1: synchronous, active-high reset.
- `scl` inout 1: bus clock. Open-drain; pulled low only for stretching.
- `sda` inout 1: bus data. Open-drain.
- `selected` out 1: high from address ACK until STOP or the next START.
- `rw` out 1: R/W bit of the current transfer (1 = master reads).
- `data_rx` out 8: last received write byte.
- `rx_valid` out 1: one-cycle pulse when `data_rx` updates.
- `rx_nack` in 1: sampled when `rx_valid` is high. 1 = NACK that byte.
- `tx_request` out 1: one-cycle pulse when a read byte is needed.
- `data_tx` in 8: read byte, captured when `tx_valid` is high.
- `tx_valid` in 1: qualifies `data_tx`.
- `stop_seen` out 1: one-cycle pulse on a STOP while selected.
- `tx_underrun` out 1: one-cycle pulse when a read byte is sent without user data.

## Operation
- Input conditioning:
  - Two-flop synchronizer, then the `FILTER_DEPTH` filter, giving `scl_f` and `sda_f`.
  - Edges are detected against the previous filtered value.
- START: `sda_f` falls while `scl_f` is high. Valid in any state, including mid-byte (repeated START). Action: release SDA, clear `selected`, enter ADDR with bit count 0.
- STOP: `sda_f` rises while `scl_f` is high. Action: release SDA and SCL, enter IDLE, pulse `stop_seen` if `selected` was high.
- START and STOP override every other event in the same cycle.
- States:
  - IDLE → ADDR (on START only).
  - ADDR: shift `sda_f` MSB-first on each `scl_f` rising edge. After 8 bits, compare the upper 7 bits with `ADDRESS`.
    - Match → ADDR_ACK; latch `rw` from bit 0.
    - Mismatch → IDLE, ignoring the bus until the next START.
  - ADDR_ACK: drive SDA low for the 9th clock; set `selected`.
    - On that clock's falling edge: `rw`=0 → RX_BYTE; `rw`=1 → TX_BYTE, pulsing `tx_request` at the ACK rising edge.
  - RX_BYTE: shift 8 bits. After the 8th rising edge, update `data_rx` and pulse `rx_valid` the next cycle → RX_ACK.
  - RX_ACK: drive SDA = `rx_nack` as latched with `rx_valid`.
    - ACK → RX_BYTE after the falling edge.
    - NACK → IDLE after the falling edge.
  - TX_BYTE: present bit 7 first. Each subsequent bit is presented after the previous `scl_f` falling edge. After 8 bits, release SDA → TX_ACK.
  - TX_ACK: sample master ACK on the rising edge.
    - ACK (`sda_f`=0) → pulse `tx_request`, then TX_BYTE.
    - NACK → IDLE (SDA released, awaiting STOP).
- Read-data handshake:
  - `tx_valid` is accepted any cycle from the `tx_request` pulse until the falling edge that begins the byte.
  - A `tx_valid` at any other time is ignored.
  - No valid data by that falling edge → see Configuration.
- Address 7'h00 (general call) is not matched unless it equals `ADDRESS`.

## Timing
- Reset values: `selected`=0, `rw`=0, `data_rx`=8'h00, `rx_valid`=0, `tx_request`=0, `stop_seen`=0, `tx_underrun`=0. SDA and SCL are released. State is IDLE.
- Reset mid-transfer: the bus is released in the same cycle. The block is deaf until the next START.
- Bus-to-internal latency: 2 + `FILTER_DEPTH` cycles.
- SDA output changes exactly 1 cycle after the filtered SCL falling edge. It never changes while `scl_f` is high, except on a START/STOP release.
- `rx_valid` fires 1 cycle after the 8th data rising edge. `tx_request` fires 1 cycle after the ACK rising edge.

## Configuration
- `I2C_TARGET_CLOCK_STRETCH_EN` defined:
  - At the falling edge that begins a read byte, if no data is held, pull SCL low until `tx_valid`.
  - Release SCL 1 cycle after `tx_valid`, with bit 7 already on SDA.
  - The same stretch applies after `rx_valid` until 1 cycle later, so the user can compute `rx_nack`.
- Undefined:
  - SCL is never driven.
  - A missing read byte sends 8'hFF and pulses `tx_underrun`.
  - `rx_nack` must be valid in the same cycle as `rx_valid`.

## Test plan
- START, write 0xA0 (address 0x50, W), data 0x3C, STOP → ACK on both bytes; `rx_valid` once with `data_rx`=0x3C; `stop_seen` once.
- START, 0xA2 (address 0x51) → no ACK (SDA high on 9th clock), `selected`=0, no pulses.
- START, 0xA1, user answers `tx_request` with 0x96 then 0x5A, master ACKs then NACKs, STOP → bus bits 10010110, 01011010; exactly 2 `tx_request` pulses.
- Write 0xA0, 0x11, then repeated START 0xA1 → state restarts at ADDR; `rw`=1 after the ACK; read proceeds.
- With the macro defined, delay `tx_valid` 50 cycles → SCL held low ≥50 cycles and released 1 cycle after `tx_valid`. Without the macro → byte 0xFF and a `tx_underrun` pulse.
- Assert `reset` mid data byte with SDA driven low → SDA released the next cycle; a later START 0xA0 is ACKed normally.

Source files
------------

// File: rtl/i2c_target.sv
// i2c_target -- I2C target (slave) with a fixed 7-bit address.
//
// Oversamples scl/sda on clk_in (two-flop synchronizer plus FILTER_DEPTH
// glitch filter) and detects START, repeated START and STOP. It ACKs
// ADDRESS, then hands write bytes to the user (data_rx/rx_valid) and
// fetches read bytes from the user (tx_request -> data_tx/tx_valid).
//
// Optional feature macro: I2C_TARGET_CLOCK_STRETCH_EN
//   defined   : SCL is held low while a read byte is missing, and while
//               rx_nack is sampled (one cycle after rx_valid).
//   undefined : SCL is never driven; a missing read byte goes out as 8'hFF
//               with a tx_underrun pulse; rx_nack is sampled with rx_valid.
//
// Ports:
//   clk_in, reset     system clock, synchronous active-high reset
//   scl, sda          open-drain bus pins (only ever pulled low)
//   selected, rw      addressed flag and R/W bit of the current transfer
//   data_rx, rx_valid received write byte and its one-cycle strobe
//   rx_nack           1 = NACK the byte strobed by rx_valid
//   tx_request        one-cycle request for the next read byte
//   data_tx, tx_valid read byte from the user and its qualifier
//   stop_seen         STOP observed while selected
//   tx_underrun       a read byte was sent without user data
module i2c_target #(
    parameter logic [6:0] ADDRESS      = 7'h50,
    parameter int         FILTER_DEPTH = 3
) (
    input  logic       clk_in,
    input  logic       reset,
    inout  wire        scl,
    inout  wire        sda,
    output logic       selected,
    output logic       rw,
    output logic [7:0] data_rx,
    output logic       rx_valid,
    input  logic       rx_nack,
    output logic       tx_request,
    input  logic [7:0] data_tx,
    input  logic       tx_valid,
    output logic       stop_seen,
    output logic       tx_underrun
);

`ifdef I2C_TARGET_CLOCK_STRETCH_EN
    localparam bit STRETCH = 1'b1;
`else
    localparam bit STRETCH = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_RX_BYTE, ST_RX_ACK, ST_TX_BYTE, ST_TX_ACK
    } state_t;

    // ---------------------------------------------------------------
    // Input conditioning. Index 0 = scl, index 1 = sda.
    // ---------------------------------------------------------------
    logic       scl_in, sda_in;
    logic [1:0] s1_q, s1_d, s2_q, s2_d;
    logic [1:0] filt_q, filt_d, filt_prev_q, filt_prev_d;
    logic [1:0][2:0] fcnt_q, fcnt_d;

    assign scl_in = scl;
    assign sda_in = sda;

    always_comb begin
        s1_d        = {sda_in, scl_in};
        s2_d        = s1_q;
        filt_prev_d = filt_q;
        for (int i = 0; i < 2; i++) begin
            filt_d[i] = filt_q[i];
            fcnt_d[i] = '0;
            // The filtered level only moves after FILTER_DEPTH consecutive
            // samples disagree with it; any agreeing sample restarts the count.
            if (s2_q[i] != filt_q[i]) begin
                if (fcnt_q[i] == 3'(FILTER_DEPTH - 1)) filt_d[i] = s2_q[i];
                else                                    fcnt_d[i] = fcnt_q[i] + 3'd1;
            end
        end
    end

    logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
    assign scl_f     = filt_q[0];
    assign sda_f     = filt_q[1];
    assign scl_rise  =  scl_f & ~filt_prev_q[0];
    assign scl_fall  = ~scl_f &  filt_prev_q[0];
    // SCL must be high in both samples so an SCL edge never fakes a condition.
    assign start_det = scl_f & filt_prev_q[0] &  filt_prev_q[1] & ~sda_f;
    assign stop_det  = scl_f & filt_prev_q[0] & ~filt_prev_q[1] &  sda_f;

    // ---------------------------------------------------------------
    // Protocol FSM
    // ---------------------------------------------------------------
    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;      // 0..7 data bits, 8..10 ACK phases
    logic [6:0] shift_q, shift_d;
    logic [6:0] tx_shift_q, tx_shift_d;    // remaining read bits after bit 7
    logic [7:0] tx_hold_q, tx_hold_d;
    logic       tx_have_q, tx_have_d;      // user byte captured for next read
    logic       tx_win_q, tx_win_d;        // tx_valid acceptance window
    logic       tx_wait_q, tx_wait_d;      // stretching for a missing read byte
    logic       nack_q, nack_d;
    logic       nack_pend_q, nack_pend_d;
    logic       sda_oe_q, sda_oe_d;
    logic       scl_oe_q, scl_oe_d;
    logic       selected_q, selected_d;
    logic       rw_q, rw_d;
    logic [7:0] data_rx_q, data_rx_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_request_q, tx_request_d;
    logic       stop_seen_q, stop_seen_d;
    logic       tx_underrun_q, tx_underrun_d;

    logic [7:0] rx_byte, tx_byte;
    logic       tx_ready, begin_tx, nack_sample;

    assign rx_byte  = {shift_q, sda_f};
    assign tx_ready = tx_have_q | (tx_win_q & tx_valid);
    assign tx_byte  = tx_have_q ? tx_hold_q : data_tx;
    // Without stretching the user must present rx_nack alongside rx_valid;
    // with stretching it gets one extra cycle.
    assign nack_sample = nack_pend_q & (STRETCH ? ~rx_valid_q : rx_valid_q);

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        tx_shift_d    = tx_shift_q;
        tx_hold_d     = tx_hold_q;
        tx_have_d     = tx_have_q;
        tx_win_d      = tx_win_q;
        tx_wait_d     = tx_wait_q;
        nack_d        = nack_q;
        nack_pend_d   = nack_pend_q;
        sda_oe_d      = sda_oe_q;
        scl_oe_d      = scl_oe_q;
        selected_d    = selected_q;
        rw_d          = rw_q;
        data_rx_d     = data_rx_q;
        rx_valid_d    = 1'b0;
        tx_request_d  = 1'b0;
        stop_seen_d   = 1'b0;
        tx_underrun_d = 1'b0;
        begin_tx      = 1'b0;

        if (tx_win_q && tx_valid && !tx_have_q) begin
            tx_hold_d = data_tx;
            tx_have_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: ;

            ST_ADDR: if (scl_rise) begin
                shift_d = rx_byte[6:0];
                if (bit_cnt_q == 4'd7) begin
                    if (rx_byte[7:1] == ADDRESS) begin
                        rw_d      = rx_byte[0];
                        bit_cnt_d = 4'd8;
                        state_d   = ST_ADDR_ACK;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end

            ST_ADDR_ACK: begin
                if (bit_cnt_q == 4'd8 && scl_fall) begin
                    sda_oe_d   = 1'b1;
                    selected_d = 1'b1;
                    bit_cnt_d  = 4'd9;
                end else if (bit_cnt_q == 4'd9 && scl_rise) begin
                    bit_cnt_d = 4'd10;
                    if (rw_q) begin
                        tx_request_d = 1'b1;
                        tx_win_d     = 1'b1;
                    end
                end else if (bit_cnt_q == 4'd10 && scl_fall) begin
                    if (rw_q) begin
                        begin_tx = 1'b1;
                    end else begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = ST_RX_BYTE;
                    end
                end
            end

            ST_RX_BYTE: if (scl_rise) begin
                shift_d = rx_byte[6:0];
                if (bit_cnt_q == 4'd7) begin
                    data_rx_d   = rx_byte;
                    rx_valid_d  = 1'b1;
                    nack_pend_d = 1'b1;
                    bit_cnt_d   = 4'd8;
                    state_d     = ST_RX_ACK;
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end

            ST_RX_ACK: begin
                if (nack_sample) begin
                    nack_d      = rx_nack;
                    nack_pend_d = 1'b0;
                end
                if (bit_cnt_q == 4'd8 && (scl_fall || scl_oe_q)) begin
                    if (nack_pend_q) begin
                        // Decision not in yet: hold SCL low until it is.
                        scl_oe_d = STRETCH;
                    end else begin
                        sda_oe_d  = ~nack_q;
                        scl_oe_d  = 1'b0;
                        bit_cnt_d = 4'd9;
                    end
                end else if (bit_cnt_q == 4'd9 && scl_rise) begin
                    bit_cnt_d = 4'd10;
                end else if (bit_cnt_q == 4'd10 && scl_fall) begin
                    sda_oe_d  = 1'b0;
                    bit_cnt_d = 4'd0;
                    state_d   = nack_q ? ST_IDLE : ST_RX_BYTE;
                end
            end

            ST_TX_BYTE: begin
                if (tx_wait_q) begin
                    // SCL is held low; release it the cycle after the data
                    // arrives, with bit 7 placed on SDA at the same time.
                    if (tx_valid) begin
                        tx_shift_d = data_tx[6:0];
                        sda_oe_d   = ~data_tx[7];
                        scl_oe_d   = 1'b0;
                        tx_wait_d  = 1'b0;
                        tx_win_d   = 1'b0;
                        tx_have_d  = 1'b0;
                    end
                end else if (scl_fall) begin
                    if (bit_cnt_q == 4'd7) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd9;
                        state_d   = ST_TX_ACK;
                    end else begin
                        sda_oe_d   = ~tx_shift_q[6];
                        tx_shift_d = {tx_shift_q[5:0], 1'b1};
                        bit_cnt_d  = bit_cnt_q + 4'd1;
                    end
                end
            end

            ST_TX_ACK: begin
                if (bit_cnt_q == 4'd9 && scl_rise) begin
                    if (!sda_f) begin
                        tx_request_d = 1'b1;
                        tx_win_d     = 1'b1;
                        bit_cnt_d    = 4'd10;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (bit_cnt_q == 4'd10 && scl_fall) begin
                    begin_tx = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Falling edge that opens a read byte: the acceptance window closes.
        if (begin_tx) begin
            state_d   = ST_TX_BYTE;
            bit_cnt_d = 4'd0;
            tx_have_d = 1'b0;
            tx_win_d  = 1'b0;
            if (tx_ready) begin
                tx_shift_d = tx_byte[6:0];
                sda_oe_d   = ~tx_byte[7];
            end else if (STRETCH) begin
                sda_oe_d  = 1'b0;
                scl_oe_d  = 1'b1;
                tx_wait_d = 1'b1;
                tx_win_d  = 1'b1;
            end else begin
                tx_shift_d    = 7'h7F;
                sda_oe_d      = 1'b0;
                tx_underrun_d = 1'b1;
            end
        end

        // START/STOP win over everything decided above.
        if (start_det || stop_det) begin
            state_d       = start_det ? ST_ADDR : ST_IDLE;
            stop_seen_d   = stop_det & selected_q;
            bit_cnt_d     = 4'd0;
            sda_oe_d      = 1'b0;
            scl_oe_d      = 1'b0;
            selected_d    = 1'b0;
            tx_have_d     = 1'b0;
            tx_win_d      = 1'b0;
            tx_wait_d     = 1'b0;
            nack_pend_d   = 1'b0;
            rx_valid_d    = 1'b0;
            tx_request_d  = 1'b0;
            tx_underrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            s1_q          <= 2'b11;
            s2_q          <= 2'b11;
            filt_q        <= 2'b11;
            filt_prev_q   <= 2'b11;
            fcnt_q        <= '0;
            state_q       <= ST_IDLE;
            bit_cnt_q     <= 4'd0;
            shift_q       <= '0;
            tx_shift_q    <= '0;
            tx_hold_q     <= '0;
            tx_have_q     <= 1'b0;
            tx_win_q      <= 1'b0;
            tx_wait_q     <= 1'b0;
            nack_q        <= 1'b0;
            nack_pend_q   <= 1'b0;
            sda_oe_q      <= 1'b0;
            scl_oe_q      <= 1'b0;
            selected_q    <= 1'b0;
            rw_q          <= 1'b0;
            data_rx_q     <= 8'h00;
            rx_valid_q    <= 1'b0;
            tx_request_q  <= 1'b0;
            stop_seen_q   <= 1'b0;
            tx_underrun_q <= 1'b0;
        end else begin
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            filt_q        <= filt_d;
            filt_prev_q   <= filt_prev_d;
            fcnt_q        <= fcnt_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            tx_shift_q    <= tx_shift_d;
            tx_hold_q     <= tx_hold_d;
            tx_have_q     <= tx_have_d;
            tx_win_q      <= tx_win_d;
            tx_wait_q     <= tx_wait_d;
            nack_q        <= nack_d;
            nack_pend_q   <= nack_pend_d;
            sda_oe_q      <= sda_oe_d;
            scl_oe_q      <= scl_oe_d;
            selected_q    <= selected_d;
            rw_q          <= rw_d;
            data_rx_q     <= data_rx_d;
            rx_valid_q    <= rx_valid_d;
            tx_request_q  <= tx_request_d;
            stop_seen_q   <= stop_seen_d;
            tx_underrun_q <= tx_underrun_d;
        end
    end

    // Reset gates the drivers directly so the bus is freed without waiting
    // for the clock edge.
    assign sda = (sda_oe_q && !reset) ? 1'b0 : 1'bz;
    assign scl = (scl_oe_q && !reset) ? 1'b0 : 1'bz;

    assign selected    = selected_q;
    assign rw          = rw_q;
    assign data_rx     = data_rx_q;
    assign rx_valid    = rx_valid_q;
    assign tx_request  = tx_request_q;
    assign stop_seen   = stop_seen_q;
    assign tx_underrun = tx_underrun_q;

endmodule
